// File: rtl/jelly_rtos_pkg.sv
// ---------------------------------------------------------------------------
// jelly_rtos_pkg
//   Shared definitions for the RTOS scheduler host interface:
//   - opcode constants (upper address byte) for register and command space
//   - REF_CFG_* / CPU_CTL_* register IDs (lower address byte)
//   - address decode positions
//   - Wishbone responder FSM state encoding
//   - is_cmd_opcode(): tells the bus logic which opcodes are service calls
// ---------------------------------------------------------------------------
package jelly_rtos_pkg;

  // Address layout: {opcode, id}
  localparam int ADR_ID_LSB     = 0;
  localparam int ADR_OPCODE_LSB = 8;
  localparam int ADR_FIELD_W    = 8;

  // Register-space opcodes
  localparam logic [7:0] OPCODE_REF_CFG     = 8'h00;
  localparam logic [7:0] OPCODE_CPU_CTL     = 8'h01;

  // Service-call opcodes (write-only, forwarded to the scheduler)
  localparam logic [7:0] OPCODE_WUP_TSK     = 8'h10;
  localparam logic [7:0] OPCODE_SLP_TSK     = 8'h11;
  localparam logic [7:0] OPCODE_DLY_TSK     = 8'h18;
  localparam logic [7:0] OPCODE_SIG_SEM     = 8'h21;
  localparam logic [7:0] OPCODE_WAI_SEM     = 8'h22;
  localparam logic [7:0] OPCODE_SET_FLG     = 8'h31;
  localparam logic [7:0] OPCODE_CLR_FLG     = 8'h32;
  // Flag wait comes in two pattern-match flavours
  localparam logic [7:0] OPCODE_WAI_FLG_AND = 8'h33;
  localparam logic [7:0] OPCODE_WAI_FLG_OR  = 8'h34;

  // REF_CFG register IDs (read-only identification)
  localparam logic [7:0] REF_CFG_CORE_ID    = 8'h00;
  localparam logic [7:0] REF_CFG_VERSION    = 8'h01;
  localparam logic [7:0] REF_CFG_DATE       = 8'h04;

  // CPU_CTL register IDs
  localparam logic [7:0] CPU_CTL_TOP_TSKID  = 8'h00;
  localparam logic [7:0] CPU_CTL_TOP_VALID  = 8'h01;
  localparam logic [7:0] CPU_CTL_RUN_TSKID  = 8'h04;
  localparam logic [7:0] CPU_CTL_RUN_VALID  = 8'h05;
  localparam logic [7:0] CPU_CTL_IRQ_EN     = 8'h10;
  localparam logic [7:0] CPU_CTL_IRQ_STS    = 8'h11;

  // Bus responder FSM
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_ACK,
    ST_RELEASE
  } wb_state_t;

  function automatic logic is_cmd_opcode(input logic [7:0] opcode);
    return opcode inside {OPCODE_WUP_TSK, OPCODE_SLP_TSK, OPCODE_DLY_TSK,
                          OPCODE_SIG_SEM, OPCODE_WAI_SEM, OPCODE_SET_FLG,
                          OPCODE_CLR_FLG, OPCODE_WAI_FLG_AND, OPCODE_WAI_FLG_OR};
  endfunction

endpackage

// File: rtl/jelly_rtos_wb_slave.sv
// ---------------------------------------------------------------------------
// jelly_rtos_wb_slave
//   Wishbone responder in front of the RTOS scheduler core.
//   - Decodes {opcode, id} addresses, serves REF_CFG / CPU_CTL reads.
//   - Holds CPU_CTL registers RUN_TSKID, RUN_VALID, IRQ_EN.
//   - Forwards service-call writes as a valid/ready command.
//   - Drives a level dispatch interrupt (registered irq_sts).
//
// Ports
//   clk, reset_n          clock, synchronous active-low reset
//   s_wb_*                Wishbone slave (adr/dat_i/dat_o/we/sel/stb/ack)
//   cmd_*                 command to scheduler (opcode, id, data, valid/ready)
//   top_tskid, top_valid  highest-priority ready task from the scheduler
//   run_tskid, run_valid  task the CPU reports as running
//   irq                   dispatch request
// ---------------------------------------------------------------------------
module jelly_rtos_wb_slave
  import jelly_rtos_pkg::*;
#(
  parameter int          WB_ADR_WIDTH = 16,
  parameter int          WB_DAT_WIDTH = 32,
  parameter int          WB_SEL_WIDTH = WB_DAT_WIDTH / 8,
  parameter int          TSKID_WIDTH  = 4,
  parameter logic [31:0] CORE_ID      = 32'h527a_f001,
  parameter logic [31:0] VERSION      = 32'h0001_0000,
  parameter logic [31:0] DATE         = 32'h2020_0101
) (
  input  logic                    clk,
  input  logic                    reset_n,

  input  logic [WB_ADR_WIDTH-1:0] s_wb_adr_i,
  input  logic [WB_DAT_WIDTH-1:0] s_wb_dat_i,
  output logic [WB_DAT_WIDTH-1:0] s_wb_dat_o,
  input  logic                    s_wb_we_i,
  input  logic [WB_SEL_WIDTH-1:0] s_wb_sel_i,
  input  logic                    s_wb_stb_i,
  output logic                    s_wb_ack_o,

  output logic [7:0]              cmd_opcode,
  output logic [7:0]              cmd_id,
  output logic [WB_DAT_WIDTH-1:0] cmd_data,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,

  input  logic [TSKID_WIDTH-1:0]  top_tskid,
  input  logic                    top_valid,
  output logic [TSKID_WIDTH-1:0]  run_tskid,
  output logic                    run_valid,
  output logic                    irq
);

  wb_state_t state;

  // Bus address fields
  logic [7:0] bus_opcode;
  logic [7:0] bus_id;
  assign bus_opcode = s_wb_adr_i[ADR_OPCODE_LSB +: ADR_FIELD_W];
  assign bus_id     = s_wb_adr_i[ADR_ID_LSB     +: ADR_FIELD_W];

  // Request captured in IDLE and acted on in ACK. Every RW field fits in
  // byte lane 0, so only lane 0's enable and the field-wide data bits are kept.
  logic [7:0]             req_opcode;
  logic [7:0]             req_id;
  logic                   req_we;
  logic                   req_lane0;
  logic [TSKID_WIDTH-1:0] req_wdat;

  logic irq_en;
  logic irq_sts;

  assign irq_sts = irq_en & top_valid & (~run_valid | (top_tskid != run_tskid));

  // Read data mux
  logic [WB_DAT_WIDTH-1:0] rd_data;

  always_comb begin
    // NOTE: default first so every path assigns rd_data and no latch is inferred.
    rd_data = '0;
    unique case (req_opcode)
      OPCODE_REF_CFG: begin
        unique case (req_id)
          REF_CFG_CORE_ID: rd_data = WB_DAT_WIDTH'(CORE_ID);
          REF_CFG_VERSION: rd_data = WB_DAT_WIDTH'(VERSION);
          REF_CFG_DATE:    rd_data = WB_DAT_WIDTH'(DATE);
          default:         rd_data = '0;
        endcase
      end
      OPCODE_CPU_CTL: begin
        unique case (req_id)
          CPU_CTL_TOP_TSKID: rd_data = WB_DAT_WIDTH'(top_tskid);
          CPU_CTL_TOP_VALID: rd_data = WB_DAT_WIDTH'(top_valid);
          CPU_CTL_RUN_TSKID: rd_data = WB_DAT_WIDTH'(run_tskid);
          CPU_CTL_RUN_VALID: rd_data = WB_DAT_WIDTH'(run_valid);
          CPU_CTL_IRQ_EN:    rd_data = WB_DAT_WIDTH'(irq_en);
          CPU_CTL_IRQ_STS:   rd_data = WB_DAT_WIDTH'(irq_sts);
          default:           rd_data = '0;
        endcase
      end
      default: rd_data = '0;
    endcase
  end

  // Responder FSM, registers and command channel
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      s_wb_ack_o <= 1'b0;
      s_wb_dat_o <= '0;
      cmd_opcode <= '0;
      cmd_id     <= '0;
      cmd_data   <= '0;
      cmd_valid  <= 1'b0;
      run_tskid  <= '0;
      run_valid  <= 1'b0;
      irq_en     <= 1'b0;
      irq        <= 1'b0;
      req_opcode <= '0;
      req_id     <= '0;
      req_we     <= 1'b0;
      req_lane0  <= 1'b0;
      req_wdat   <= '0;
    end else begin
      // NOTE: non-blocking throughout; every read in this block sees pre-edge values.
      s_wb_ack_o <= 1'b0;
      irq        <= irq_sts;

      unique case (state)
        ST_IDLE: begin
          if (s_wb_stb_i) begin
            req_opcode <= bus_opcode;
            req_id     <= bus_id;
            req_we     <= s_wb_we_i;
            req_lane0  <= s_wb_sel_i[0];
            req_wdat   <= s_wb_dat_i[TSKID_WIDTH-1:0];
            // A command write with no byte lanes enabled is acked but dropped
            if (s_wb_we_i && is_cmd_opcode(bus_opcode) && (|s_wb_sel_i)) begin
              cmd_opcode <= bus_opcode;
              cmd_id     <= bus_id;
              cmd_data   <= s_wb_dat_i;
              cmd_valid  <= 1'b1;
              state      <= ST_CMD;
            end else begin
              state      <= ST_ACK;
            end
          end
        end

        // Completes even if the master abandons stb; the command is already out
        ST_CMD: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= ST_ACK;
          end
        end

        ST_ACK: begin
          s_wb_ack_o <= 1'b1;
          state      <= ST_RELEASE;
          if (!req_we) begin
            // Read data only moves on reads so it stays stable across writes
            s_wb_dat_o <= rd_data;
          end else if (req_opcode == OPCODE_CPU_CTL && req_lane0) begin
            unique case (req_id)
              CPU_CTL_RUN_TSKID: run_tskid <= req_wdat;
              CPU_CTL_RUN_VALID: run_valid <= req_wdat[0];
              CPU_CTL_IRQ_EN:    irq_en    <= req_wdat[0];
              default: ;
            endcase
          end
        end

        // Hold off until the master drops stb so one cycle of stb after ack
        // cannot start a second transaction
        ST_RELEASE: begin
          if (!s_wb_stb_i) begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jelly_rtos_wb_slave.sv
// ---------------------------------------------------------------------------
// tb_jelly_rtos_wb_slave
//   Self-checking bench for jelly_rtos_wb_slave: directed scenarios followed
//   by randomized bus accesses checked against a register-level model.
// ---------------------------------------------------------------------------
module tb_jelly_rtos_wb_slave;

  logic        clk;
  logic        reset_n;
  logic [15:0] s_wb_adr_i;
  logic [31:0] s_wb_dat_i;
  logic [31:0] s_wb_dat_o;
  logic        s_wb_we_i;
  logic [3:0]  s_wb_sel_i;
  logic        s_wb_stb_i;
  logic        s_wb_ack_o;
  logic [7:0]  cmd_opcode;
  logic [7:0]  cmd_id;
  logic [31:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  top_tskid;
  logic        top_valid;
  logic [3:0]  run_tskid;
  logic        run_valid;
  logic        irq;

  jelly_rtos_wb_slave dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .s_wb_adr_i (s_wb_adr_i),
    .s_wb_dat_i (s_wb_dat_i),
    .s_wb_dat_o (s_wb_dat_o),
    .s_wb_we_i  (s_wb_we_i),
    .s_wb_sel_i (s_wb_sel_i),
    .s_wb_stb_i (s_wb_stb_i),
    .s_wb_ack_o (s_wb_ack_o),
    .cmd_opcode (cmd_opcode),
    .cmd_id     (cmd_id),
    .cmd_data   (cmd_data),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .top_tskid  (top_tskid),
    .top_valid  (top_valid),
    .run_tskid  (run_tskid),
    .run_valid  (run_valid),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [3:0]  m_run_tskid = '0;
  logic        m_run_valid = 1'b0;
  logic        m_irq_en    = 1'b0;
  logic [31:0] last_rd     = '0;
  logic [47:0] cmd_log[$];

  logic [15:0] addr_pool [0:19] = '{
    16'h0000, 16'h0001, 16'h0004, 16'h0002, 16'h0100, 16'h0101, 16'h0104,
    16'h0105, 16'h0110, 16'h0111, 16'h0106, 16'h1003, 16'h1105, 16'h1800,
    16'h2102, 16'h2201, 16'h3107, 16'h3200, 16'h3304, 16'h3409
  };

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic is_cmd(input logic [7:0] op);
    return op inside {8'h10, 8'h11, 8'h18, 8'h21, 8'h22, 8'h31, 8'h32, 8'h33, 8'h34};
  endfunction

  function automatic logic model_sts();
    return m_irq_en && top_valid && (!m_run_valid || (top_tskid != m_run_tskid));
  endfunction

  function automatic logic [31:0] exp_read(input logic [15:0] adr);
    case (adr)
      16'h0000: return 32'h527a_f001;
      16'h0001: return 32'h0001_0000;
      16'h0004: return 32'h2020_0101;
      16'h0100: return {28'd0, top_tskid};
      16'h0101: return {31'd0, top_valid};
      16'h0104: return {28'd0, m_run_tskid};
      16'h0105: return {31'd0, m_run_valid};
      16'h0110: return {31'd0, m_irq_en};
      16'h0111: return {31'd0, model_sts()};
      default:  return 32'd0;
    endcase
  endfunction

  task automatic model_write(input logic [15:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    if (sel[0]) begin
      case (adr)
        16'h0104: m_run_tskid = dat[3:0];
        16'h0105: m_run_valid = dat[0];
        16'h0110: m_irq_en    = dat[0];
        default: ;
      endcase
    end
  endtask

  // One bus access; also plays the scheduler side (cmd_ready after 'hold' cycles)
  task automatic wb_access(input string tag, input logic [15:0] adr, input logic we,
                           input logic [31:0] dat, input logic [3:0] sel,
                           input int hold, input int extra,
                           output logic [31:0] rdata, output int ack_cnt,
                           output int first_ack, output int valid_cycles);
    int   post;
    int   stb_left;
    logic done;
    post = 0; stb_left = 0; done = 1'b0;
    ack_cnt = 0; first_ack = -1; valid_cycles = 0; rdata = '0;
    @(negedge clk);
    s_wb_adr_i = adr; s_wb_we_i = we; s_wb_dat_i = dat; s_wb_sel_i = sel;
    s_wb_stb_i = 1'b1; cmd_ready = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      if (cmd_valid) begin
        valid_cycles++;
        check({tag, "/cmd_payload"}, {16'd0, cmd_opcode, cmd_id, cmd_data}, {16'd0, adr, dat});
        if (hold > 0) begin
          hold--;
          cmd_ready = 1'b0;
        end else begin
          cmd_ready = 1'b1;
          cmd_log.push_back({cmd_opcode, cmd_id, cmd_data});
        end
      end else begin
        cmd_ready = 1'b0;
      end
      if (s_wb_ack_o) begin
        ack_cnt++;
        if (first_ack < 0) first_ack = c;
        rdata    = s_wb_dat_o;
        stb_left = extra;
      end
      if (ack_cnt > 0) begin
        if (stb_left > 0) stb_left--;
        else              s_wb_stb_i = 1'b0;
        post++;
        if (post > 4) done = 1'b1;
      end
    end
    s_wb_stb_i = 1'b0; s_wb_we_i = 1'b0; cmd_ready = 1'b0;
  endtask

  task automatic do_access(input string tag, input logic [15:0] adr, input logic we,
                           input logic [31:0] dat, input logic [3:0] sel,
                           input int hold, input int extra);
    logic [31:0] rd;
    logic [31:0] exp_rd;
    int          acks;
    int          first;
    int          vcyc;
    int          log0;
    logic        exp_cmd;
    exp_cmd = we && is_cmd(adr[15:8]) && (sel != 4'd0);
    exp_rd  = exp_read(adr);
    log0    = cmd_log.size();
    wb_access(tag, adr, we, dat, sel, hold, extra, rd, acks, first, vcyc);
    check({tag, "/ack_count"}, 64'(acks), 64'd1);
    check({tag, "/ack_latency"}, 64'(first), exp_cmd ? 64'(hold + 2) : 64'd1);
    check({tag, "/valid_cycles"}, 64'(vcyc), exp_cmd ? 64'(hold + 1) : 64'd0);
    if (!we) begin
      check({tag, "/rdata"}, 64'(rd), 64'(exp_rd));
      last_rd = exp_rd;
    end else begin
      model_write(adr, dat, sel);
    end
    check({tag, "/cmd_count"}, 64'(cmd_log.size()), 64'(log0 + (exp_cmd ? 1 : 0)));
    if (exp_cmd && cmd_log.size() > log0)
      check({tag, "/cmd_entry"}, 64'(cmd_log[log0]), {16'd0, adr, dat});
    check({tag, "/dat_o_hold"}, 64'(s_wb_dat_o), 64'(last_rd));
    check({tag, "/irq"}, 64'(irq), 64'(model_sts()));
    check({tag, "/run_regs"}, {59'd0, run_valid, run_tskid}, {59'd0, m_run_valid, m_run_tskid});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic        seen;
    logic [15:0] adr;
    reset_n    = 1'b0;
    s_wb_adr_i = '0; s_wb_dat_i = '0; s_wb_we_i = 1'b0; s_wb_sel_i = '0;
    s_wb_stb_i = 1'b0; cmd_ready = 1'b0; top_tskid = '0; top_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset/ack",       64'(s_wb_ack_o), 64'd0);
    check("reset/dat_o",     64'(s_wb_dat_o), 64'd0);
    check("reset/cmd_valid", 64'(cmd_valid),  64'd0);
    check("reset/cmd_bus",   {16'd0, cmd_opcode, cmd_id, cmd_data}, 64'd0);
    check("reset/run",       {59'd0, run_valid, run_tskid}, 64'd0);
    check("reset/irq",       64'(irq), 64'd0);
    reset_n = 1'b1;

    // Directed scenarios
    do_access("rd_core_id",   16'h0000, 1'b0, 32'd0, 4'hf, 0, 0);
    do_access("rd_run_tskid", 16'h0104, 1'b0, 32'd0, 4'hf, 0, 0);
    do_access("rd_cmd_space", 16'h2200, 1'b0, 32'd0, 4'hf, 0, 0);
    do_access("wr_run_tskid", 16'h0104, 1'b1, 32'd3, 4'hf, 0, 0);
    do_access("wr_run_valid", 16'h0105, 1'b1, 32'd1, 4'hf, 0, 0);
    do_access("rb_run_tskid", 16'h0104, 1'b0, 32'd0, 4'hf, 0, 0);
    do_access("rb_run_valid", 16'h0105, 1'b0, 32'd0, 4'hf, 0, 0);
    do_access("wr_irq_sts",   16'h0111, 1'b1, 32'd1, 4'hf, 0, 0);
    do_access("rb_irq_sts",   16'h0111, 1'b0, 32'd0, 4'hf, 0, 0);
    @(negedge clk);
    top_valid = 1'b1; top_tskid = 4'd2;
    do_access("wr_irq_en",    16'h0110, 1'b1, 32'd1, 4'hf, 0, 0);
    do_access("rd_irq_sts_1", 16'h0111, 1'b0, 32'd0, 4'hf, 0, 0);
    do_access("wr_run_eq_top",16'h0104, 1'b1, 32'd2, 4'hf, 0, 0);
    do_access("cmd_wup_hold", 16'h1001, 1'b1, 32'd0, 4'hf, 5, 0);
    do_access("cmd_dly_stb",  16'h1801, 1'b1, 32'd10, 4'hf, 0, 1);
    do_access("cmd_sel0",     16'h2101, 1'b1, 32'h55, 4'h0, 0, 0);
    do_access("wr_lane1_only",16'h0104, 1'b1, 32'h0000_0505, 4'b0010, 0, 0);
    do_access("rb_after_lane",16'h0104, 1'b0, 32'd0, 4'hf, 0, 0);

    // Reset while a command is waiting for ready
    @(negedge clk);
    s_wb_adr_i = 16'h3101; s_wb_we_i = 1'b1; s_wb_dat_i = 32'hdead_beef;
    s_wb_sel_i = 4'hf; s_wb_stb_i = 1'b1; cmd_ready = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = cmd_valid;
    end
    check("rst_mid/pending", 64'(cmd_valid), 64'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_mid/cmd_valid", 64'(cmd_valid), 64'd0);
    check("rst_mid/ack",       64'(s_wb_ack_o), 64'd0);
    check("rst_mid/cmd_bus",   {16'd0, cmd_opcode, cmd_id, cmd_data}, 64'd0);
    check("rst_mid/run",       {59'd0, run_valid, run_tskid}, 64'd0);
    check("rst_mid/irq",       64'(irq), 64'd0);
    s_wb_stb_i = 1'b0; s_wb_we_i = 1'b0;
    m_run_tskid = '0; m_run_valid = 1'b0; m_irq_en = 1'b0; last_rd = '0;
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_mid/no_ack", 64'(s_wb_ack_o), 64'd0);
    do_access("cmd_after_rst", 16'h1100, 1'b1, 32'h0000_1234, 4'hf, 0, 0);

    // Randomized accesses with changing scheduler inputs
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      top_tskid = 4'($urandom_range(0, 3));
      top_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("rand/irq_lag", 64'(irq), 64'(model_sts()));
      if ($urandom_range(0, 7) == 0) adr = 16'($urandom);
      else                           adr = addr_pool[$urandom_range(0, 19)];
      do_access("rand", adr, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 3)),
                ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
